// File: rtl/mul_unit_pkg.sv
// Shared types and constants for the integer multiply unit.
// Holds the FSM state encoding, RV32M Funct3 selectors and the iteration count.
// No logic; imported by mul_operand_cond and mul_unit.
package mul_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] FUNCT_MUL    = 3'b000;
   localparam logic [2:0] FUNCT_MULH   = 3'b001;
   localparam logic [2:0] FUNCT_MULHSU = 3'b010;
   localparam logic [2:0] FUNCT_MULHU  = 3'b011;

   localparam int         MUL_ITER  = 32;
   localparam logic [4:0] LAST_ITER = 5'(MUL_ITER - 1);

endpackage

// File: rtl/mul_operand_cond.sv
// Operand conditioning: converts rs1/rs2 to magnitudes and derives the result sign.
// Latency: purely combinational.
// Backpressure: none; sampled by mul_unit only when a request is accepted.
module mul_operand_cond (
   input  logic [2:0]  funct3,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic [31:0] mag_a,
   output logic [31:0] mag_b,
   output logic        neg
);
   import mul_unit_pkg::*;

   logic a_signed;
   logic b_signed;
   logic a_neg;
   logic b_neg;

   // rs1 is signed for MULH/MULHSU, rs2 only for MULH; negative signed values become magnitudes
   always_comb begin
      a_signed = (funct3 == FUNCT_MULH) || (funct3 == FUNCT_MULHSU);
      b_signed = (funct3 == FUNCT_MULH);
      a_neg    = a_signed & src_a[31];
      b_neg    = b_signed & src_b[31];
      mag_a    = a_neg ? (~src_a + 32'd1) : src_a;
      mag_b    = b_neg ? (~src_b + 32'd1) : src_b;
      neg      = a_neg ^ b_neg;
   end

endmodule

// File: rtl/mul_unit.sv
// RV32M multiply unit: shift-add over 32 CALC cycles, result written back from DONE.
// Latency: write strobe 33 cycles after the request (2 with MUL_UNIT_FAST_EN defined).
// Backpressure: MulBusy stalls decode; RegMul is ignored while in CALC.
module mul_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegMul,
   input  logic [2:0]  Funct3,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   input  logic [4:0]  Rd,
   output logic        MulBusy,
   output logic        MulWrite,
   output logic [4:0]  MulRd,
   output logic [31:0] MulResult
);
   import mul_unit_pkg::*;

   state_t      state;
   logic [2:0]  f3_q;
   logic [31:0] a_q;
   logic [4:0]  rd_q;
   logic        neg_q;
   logic [63:0] acc;
   logic [4:0]  cnt;

   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic        neg;

   logic [32:0] sum;
   logic [63:0] acc_step;
   logic [63:0] prod_mag;
   logic [63:0] prod;
   logic        calc_last;

   mul_operand_cond u_cond (
      .funct3 (Funct3),
      .src_a  (SrcA),
      .src_b  (SrcB),
      .mag_a  (mag_a),
      .mag_b  (mag_b),
      .neg    (neg)
   );

   assign MulBusy = (state != IDLE);

   // One shift-add step: acc holds {partial high, remaining multiplier bits}; then sign fix-up
   always_comb begin
      sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_q} : 33'd0);
      acc_step = {sum, acc[31:1]};
`ifdef MUL_UNIT_FAST_EN
      prod_mag  = {32'd0, a_q} * {32'd0, acc[31:0]};
      calc_last = 1'b1;
`else
      prod_mag  = acc_step;
      calc_last = (cnt == LAST_ITER);
`endif
      prod = neg_q ? (~prod_mag + 64'd1) : prod_mag;
   end

   // Control FSM with registered write-back outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         f3_q      <= 3'd0;
         a_q       <= 32'd0;
         rd_q      <= 5'd0;
         neg_q     <= 1'b0;
         acc       <= 64'd0;
         cnt       <= 5'd0;
         MulWrite  <= 1'b0;
         MulRd     <= 5'd0;
         MulResult <= 32'd0;
      end else begin
         MulWrite <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (RegMul) begin
                  f3_q  <= Funct3;
                  a_q   <= mag_a;
                  rd_q  <= Rd;
                  neg_q <= neg;
                  acc   <= {32'd0, mag_b};
                  cnt   <= 5'd0;
                  if (Funct3[2]) begin
                     // Unsupported encodings pass straight through DONE with a zero result and no write
                     state     <= DONE;
                     MulRd     <= Rd;
                     MulResult <= 32'd0;
                  end else begin
                     state <= CALC;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               cnt <= cnt + 5'd1;
               if (calc_last) begin
                  acc       <= prod;
                  state     <= DONE;
                  MulWrite  <= (rd_q != 5'd0);
                  MulRd     <= rd_q;
                  MulResult <= (f3_q == FUNCT_MUL) ? prod[31:0] : prod[63:32];
               end else begin
                  acc <= acc_step;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus randomized operations.
// Expected write-backs are queued at issue time and matched by a negedge monitor.
// Latency follows MUL_UNIT_FAST_EN when the bench is built with it.
module tb_mul_unit;
   import mul_unit_pkg::*;

`ifdef MUL_UNIT_FAST_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RegMul = 1'b0;
   logic [2:0]  Funct3 = 3'd0;
   logic [31:0] SrcA = 32'd0;
   logic [31:0] SrcB = 32'd0;
   logic [4:0]  Rd = 5'd0;
   logic        MulBusy;
   logic        MulWrite;
   logic [4:0]  MulRd;
   logic [31:0] MulResult;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] res;
      int          due;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   mul_unit dut (
      .clk       (clk),
      .rst       (rst),
      .RegMul    (RegMul),
      .Funct3    (Funct3),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .Rd        (Rd),
      .MulBusy   (MulBusy),
      .MulWrite  (MulWrite),
      .MulRd     (MulRd),
      .MulResult (MulResult)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Architectural reference: sign/zero-extend to 64 bits and multiply
   function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      logic [63:0] p;
      if (f3[2]) return 32'd0;
      ea = (f3 == FUNCT_MULH || f3 == FUNCT_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
      eb = (f3 == FUNCT_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return (f3 == FUNCT_MUL) ? p[31:0] : p[63:32];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every write strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && MulWrite === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: MulRd=%0d MulResult=%08h at cycle %0d, expected no write",
                     MulRd, MulResult, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("wb_rd", 64'(MulRd), 64'(mon_e.rd));
            chk("wb_result", 64'(MulResult), 64'(mon_e.res));
            chk("wb_cycle", 64'(cyc), 64'(mon_e.due));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a one-cycle request and record its expected write-back
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      exp_t e;
      Funct3 = f3;
      SrcA   = a;
      SrcB   = b;
      Rd     = rd;
      RegMul = 1'b1;
      if (rd != 5'd0 && !f3[2]) begin
         e.rd  = rd;
         e.res = ref_res(f3, a, b);
         e.due = cyc + LAT;
         sb.push_back(e);
      end
      step();
      RegMul = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (MulBusy && n < 100) begin
         step();
         n++;
      end
      chk("idle_reached", 64'(MulBusy), 64'd0);
   endtask

   function automatic logic [31:0] pick_op();
      logic [31:0] corners [6];
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'hFFFF_FFFF;
      corners[3] = 32'h8000_0000;
      corners[4] = 32'h7FFF_FFFF;
      corners[5] = 32'h0001_0000;
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit busy_ok;
      logic [2:0] f3;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(MulBusy), 64'd0);
      chk("rst_write", 64'(MulWrite), 64'd0);
      chk("rst_rd", 64'(MulRd), 64'd0);
      chk("rst_result", 64'(MulResult), 64'd0);
      rst = 1'b0;
      step();

      // MUL 7x6 -> 42 at the expected latency, busy throughout
      issue(FUNCT_MUL, 32'd7, 32'd6, 5'd5);
      busy_ok = MulBusy;
      repeat (LAT - 1) begin
         step();
         if (!MulBusy) busy_ok = 1'b0;
      end
      chk("mul_busy_window", 64'(busy_ok), 64'd1);
      chk("mul_done_write", 64'(MulWrite), 64'd1);
      chk("mul_done_rd", 64'(MulRd), 64'd5);
      chk("mul_done_result", 64'(MulResult), 64'd42);
      step();
      chk("mul_after_busy", 64'(MulBusy), 64'd0);
      chk("mul_after_write", 64'(MulWrite), 64'd0);
      chk("mul_hold_result", 64'(MulResult), 64'd42);

      // Sign-handling corners
      issue(FUNCT_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1);
      wait_idle();
      chk("mulh_min", 64'(MulResult), 64'h4000_0000);
      issue(FUNCT_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      wait_idle();
      chk("mulhu_max", 64'(MulResult), 64'hFFFF_FFFE);
      issue(FUNCT_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      wait_idle();
      chk("mulhsu_neg", 64'(MulResult), 64'hFFFF_FFFF);
      issue(FUNCT_MUL, 32'hFFFF_FFFF, 32'd3, 5'd4);
      wait_idle();
      chk("mul_neg1x3", 64'(MulResult), 64'hFFFF_FFFD);

      // Rd=0: passes through DONE without a write
      issue(FUNCT_MUL, 32'd5, 32'd5, 5'd0);
      repeat (LAT - 1) step();
      chk("rd0_done_busy", 64'(MulBusy), 64'd1);
      chk("rd0_done_write", 64'(MulWrite), 64'd0);
      step();
      chk("rd0_after_busy", 64'(MulBusy), 64'd0);

      // Funct3[2]=1: one DONE cycle, zero result, no write
      issue(3'b100, 32'd9, 32'd9, 5'd6);
      chk("f3inv_busy", 64'(MulBusy), 64'd1);
      chk("f3inv_write", 64'(MulWrite), 64'd0);
      chk("f3inv_result", 64'(MulResult), 64'd0);
      step();
      chk("f3inv_after_busy", 64'(MulBusy), 64'd0);

      // RegMul during CALC is ignored
      issue(FUNCT_MUL, 32'd11, 32'd13, 5'd3);
      Funct3 = FUNCT_MUL;
      SrcA   = 32'd100;
      SrcB   = 32'd100;
      Rd     = 5'd4;
      RegMul = 1'b1;
      step();
      RegMul = 1'b0;
      wait_idle();
      repeat (3) step();

      // Reset mid-operation aborts the pending write
      issue(FUNCT_MUL, 32'h1234, 32'h55, 5'd7);
      repeat ((LAT > 11) ? 9 : 0) step();
      #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", 64'(MulBusy), 64'd0);
      chk("abort_write", 64'(MulWrite), 64'd0);
      chk("abort_rd", 64'(MulRd), 64'd0);
      chk("abort_result", 64'(MulResult), 64'd0);
      sb.delete();
      step();
      rst = 1'b0;
      repeat (40) step();
      chk("abort_idle", 64'(MulBusy), 64'd0);
      issue(FUNCT_MUL, 32'd2, 32'd3, 5'd9);
      wait_idle();
      chk("post_abort_result", 64'(MulResult), 64'd6);

      // Back-to-back: second request presented in DONE of the first
      issue(FUNCT_MULH, 32'hDEAD_BEEF, 32'h1234_5678, 5'd10);
      busy_ok = MulBusy;
      repeat (LAT - 1) begin
         step();
         if (!MulBusy) busy_ok = 1'b0;
      end
      issue(FUNCT_MULHU, 32'hCAFE_F00D, 32'h8765_4321, 5'd11);
      if (!MulBusy) busy_ok = 1'b0;
      repeat (LAT - 1) begin
         step();
         if (!MulBusy) busy_ok = 1'b0;
      end
      chk("b2b_busy", 64'(busy_ok), 64'd1);
      wait_idle();

      // Randomized operations against the reference model
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(4, 7));
         else f3 = 3'($urandom_range(0, 3));
         issue(f3, pick_op(), pick_op(), 5'($urandom_range(0, 31)));
         wait_idle();
      end

      repeat (5) step();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
